// File: rtl/wb_trace_buffer.sv
// Trace capture FIFO for retired register writebacks. Records carry PC, data and a
// sequence number. Overflowing records are dropped and counted, so the pipeline never stalls.
module wb_trace_buffer #(
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned REGISTER_WIDTH = 5,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned ADDR_WIDTH     = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      wb_valid,
    input  logic [REGISTER_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    input  logic [ADDR_WIDTH-1:0]     wb_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [REGISTER_WIDTH-1:0] out_rd,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [ADDR_WIDTH-1:0]     out_pc,
    output logic [15:0]               out_seq,
    output logic [15:0]               drop_count,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned RecW = REGISTER_WIDTH + DATA_WIDTH + ADDR_WIDTH + 16;
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

    logic [RecW-1:0] mem [DEPTH];
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [15:0]     seq_q;

    logic push;
    logic pop;
    logic store;
    logic drop;

    assign push  = wb_valid && (wb_rd != '0);
    assign pop   = out_valid && out_ready;
    // A full FIFO still accepts a record when the head leaves on the same edge.
    assign store = push && (!full || pop);
    assign drop  = push && !store;

    assign out_valid = (count != '0);
    assign empty     = (count == '0);
    assign full      = (count == FullCount);

    assign {out_rd, out_data, out_pc, out_seq} = mem[rd_ptr_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count      <= '0;
            seq_q      <= '0;
            drop_count <= '0;
        end else begin
            if (store) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (store && !pop) begin
                count <= count + (PtrW + 1)'(1);
            end else if (pop && !store) begin
                count <= count - (PtrW + 1)'(1);
            end
            // Dropped records still consume a sequence number so gaps are visible downstream.
            if (push) begin
                seq_q <= seq_q + 16'd1;
            end
            if (drop && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr_q] <= {wb_rd, wb_data, wb_pc, seq_q};
        end
    end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: a negedge scoreboard models the FIFO every cycle,
// and per-scenario tasks add targeted checks.
module tb_wb_trace_buffer;

    localparam int unsigned DEPTH = 8;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
        logic [63:0] pc;
        logic [15:0] seq;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [63:0] wb_data = '0;
    logic [63:0] wb_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_rd;
    logic [63:0] out_data;
    logic [63:0] out_pc;
    logic [15:0] out_seq;
    logic [15:0] drop_count;
    logic [3:0]  count;
    logic        full;
    logic        empty;

    int vectors = 0;
    int miscompares = 0;

    rec_t q[$];
    int   mseq = 0;
    int   mdrop = 0;

    always #5 clk = ~clk;

    wb_trace_buffer #(
        .DEPTH(DEPTH), .REGISTER_WIDTH(5), .DATA_WIDTH(64), .ADDR_WIDTH(64)
    ) dut (
        .clk(clk), .reset_n(reset_n), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_pc(wb_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_data(out_data), .out_pc(out_pc), .out_seq(out_seq),
        .drop_count(drop_count), .count(count), .full(full), .empty(empty)
    );

    // Scoreboard: compare current state, then apply the inputs the next edge will see.
    always @(negedge clk) begin
        rec_t head;
        if (!reset_n) begin
            q.delete();
            mseq  = 0;
            mdrop = 0;
        end else begin
            vectors++;
            if (out_valid !== (q.size() != 0)) begin
                miscompares++;
                $display("FAIL sb_valid: got %b want %b", out_valid, q.size() != 0);
            end
            vectors++;
            if (count !== 4'(q.size())) begin
                miscompares++;
                $display("FAIL sb_count: got %0d want %0d", count, q.size());
            end
            vectors++;
            if (drop_count !== 16'(mdrop)) begin
                miscompares++;
                $display("FAIL sb_drop: got %0d want %0d", drop_count, mdrop);
            end
            vectors++;
            if (full !== (q.size() == DEPTH) || empty !== (q.size() == 0)) begin
                miscompares++;
                $display("FAIL sb_flags: got full=%b empty=%b want size %0d", full, empty,
                         q.size());
            end
            if (q.size() != 0) begin
                head = q[0];
                vectors++;
                if ({out_rd, out_data, out_pc, out_seq} !== head) begin
                    miscompares++;
                    $display("FAIL sb_head: got rd=%0d data=%h pc=%h seq=%0d want rd=%0d data=%h pc=%h seq=%0d",
                             out_rd, out_data, out_pc, out_seq, head.rd, head.data, head.pc,
                             head.seq);
                end
                if (out_ready) void'(q.pop_front());
            end
            if (wb_valid && wb_rd != 5'd0) begin
                if (q.size() < DEPTH) begin
                    q.push_back(rec_t'{rd: wb_rd, data: wb_data, pc: wb_pc, seq: 16'(mseq)});
                end else if (mdrop < 65535) begin
                    mdrop++;
                end
                mseq = (mseq + 1) & 32'hFFFF;
            end
        end
    end

    task automatic cycle(input logic v, input logic [4:0] rd, input logic [63:0] d,
                         input logic [63:0] pc, input logic rdy);
        @(posedge clk);
        #1;
        wb_valid  = v;
        wb_rd     = rd;
        wb_data   = d;
        wb_pc     = pc;
        out_ready = rdy;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n   = 1'b0;
        wb_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic drain();
        cycle(1'b0, 5'd0, 64'd0, 64'd0, 1'b1);
        for (int k = 0; k < 20 && !empty; k++) @(negedge clk);
        vectors++;
        if (!empty) begin
            miscompares++;
            $display("FAIL drain_timeout: got count=%0d want 0", count);
        end
        cycle(1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if (out_valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || count !== 4'd0 ||
            drop_count !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_state: got v=%b e=%b f=%b cnt=%0d drop=%0d want 0 1 0 0 0",
                     out_valid, empty, full, count, drop_count);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        cycle(1'b1, 5'd5, 64'h1234, 64'h1000, 1'b0);
        cycle(1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_rd !== 5'd5 || out_seq !== 16'd0 || count !== 4'd1 ||
            out_data !== 64'h1234 || out_pc !== 64'h1000) begin
            miscompares++;
            $display("FAIL single_push: got v=%b rd=%0d seq=%0d cnt=%0d want 1 5 0 1",
                     out_valid, out_rd, out_seq, count);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
            @(negedge clk);
            vectors++;
            if (out_rd !== 5'd5 || out_data !== 64'h1234 || out_seq !== 16'd0) begin
                miscompares++;
                $display("FAIL hold_stable: got rd=%0d data=%h want 5 1234", out_rd, out_data);
            end
        end
        cycle(1'b0, 5'd0, 64'd0, 64'd0, 1'b1);
        cycle(1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
        @(negedge clk);
        vectors++;
        if (empty !== 1'b1) begin
            miscompares++;
            $display("FAIL pop_empty: got empty=%b want 1", empty);
        end
    endtask

    task automatic test_x0();
        do_reset();
        cycle(1'b1, 5'd0, 64'hDEAD, 64'h2000, 1'b0);
        cycle(1'b1, 5'd1, 64'hBEEF, 64'h2004, 1'b0);
        cycle(1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
        @(negedge clk);
        vectors++;
        if (count !== 4'd1 || out_rd !== 5'd1 || out_seq !== 16'd0 || drop_count !== 16'd0) begin
            miscompares++;
            $display("FAIL x0_ignored: got cnt=%0d rd=%0d seq=%0d drop=%0d want 1 1 0 0",
                     count, out_rd, out_seq, drop_count);
        end
        drain();
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 10; i++) cycle(1'b1, 5'(i), 64'(i * 3), 64'(32'h3000 + i * 4), 1'b0);
        cycle(1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
        @(negedge clk);
        vectors++;
        if (full !== 1'b1 || count !== 4'd8 || drop_count !== 16'd2) begin
            miscompares++;
            $display("FAIL overflow: got full=%b cnt=%0d drop=%0d want 1 8 2",
                     full, count, drop_count);
        end
        cycle(1'b0, 5'd0, 64'd0, 64'd0, 1'b1);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            vectors++;
            if (out_seq !== 16'(j)) begin
                miscompares++;
                $display("FAIL drain_seq: got %0d want %0d", out_seq, j);
            end
        end
        cycle(1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
    endtask

    // Continues from test_overflow: seq is at 10 and drop_count at 2.
    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) cycle(1'b1, 5'(i + 11), 64'(i), 64'(i * 8), 1'b0);
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, 5'(k % 31 + 1), 64'(k + 100), 64'(k * 16), 1'b1);
            @(negedge clk);
            vectors++;
            if (count !== 4'd8 || drop_count !== 16'd2 || out_seq !== 16'(10 + k)) begin
                miscompares++;
                $display("FAIL full_stream: got cnt=%0d drop=%0d seq=%0d want 8 2 %0d",
                         count, drop_count, out_seq, 10 + k);
            end
        end
        drain();
    endtask

    task automatic test_seq_wrap();
        do_reset();
        for (int i = 0; i < 65535; i++) cycle(1'b1, 5'd3, 64'(i), 64'd0, 1'b1);
        cycle(1'b1, 5'd7, 64'hAAAA, 64'h4000, 1'b1);
        cycle(1'b1, 5'd8, 64'hBBBB, 64'h4004, 1'b1);
        @(negedge clk);
        vectors++;
        if (out_seq !== 16'hFFFF || out_rd !== 5'd7) begin
            miscompares++;
            $display("FAIL seq_ffff: got seq=%h rd=%0d want ffff 7", out_seq, out_rd);
        end
        cycle(1'b0, 5'd0, 64'd0, 64'd0, 1'b1);
        @(negedge clk);
        vectors++;
        if (out_seq !== 16'h0000 || out_rd !== 5'd8) begin
            miscompares++;
            $display("FAIL seq_wrap: got seq=%h rd=%0d want 0000 8", out_seq, out_rd);
        end
        drain();
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 1; i <= 5; i++) cycle(1'b1, 5'(i), 64'(i), 64'(i), 1'b0);
        @(posedge clk);
        #2;
        vectors++;
        if (count !== 4'd5) begin
            miscompares++;
            $display("FAIL pre_reset_count: got %0d want 5", count);
        end
        #1;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || count !== 4'd0) begin
            miscompares++;
            $display("FAIL async_reset: got v=%b cnt=%0d want 0 0", out_valid, count);
        end
        wb_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (drop_count !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_drop: got %0d want 0", drop_count);
        end
        cycle(1'b1, 5'd4, 64'h55, 64'h5000, 1'b0);
        cycle(1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
        @(negedge clk);
        vectors++;
        if (out_seq !== 16'd0 || out_rd !== 5'd4) begin
            miscompares++;
            $display("FAIL reset_seq: got seq=%0d rd=%0d want 0 4", out_seq, out_rd);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_x0();
        test_overflow();
        test_back_to_back();
        test_seq_wrap();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
